// File: rtl/bcd_sseg_display_mux_pkg.sv
// Shared constants for the BCD seven-segment display driver: FSM encoding,
// blank/dash codes and the active-low digit patterns (bit 7 = dp, 6..0 = g..a).
package bcd_sseg_display_mux_pkg;

  localparam logic [1:0] ST_BLANK = 2'b00;
  localparam logic [1:0] ST_SHOW  = 2'b01;
  localparam logic [1:0] ST_SAT   = 2'b10;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;

  localparam logic [7:0] SSEG_D0 = 8'hC0;
  localparam logic [7:0] SSEG_D1 = 8'hF9;
  localparam logic [7:0] SSEG_D2 = 8'hA4;
  localparam logic [7:0] SSEG_D3 = 8'hB0;
  localparam logic [7:0] SSEG_D4 = 8'h99;
  localparam logic [7:0] SSEG_D5 = 8'h92;
  localparam logic [7:0] SSEG_D6 = 8'h82;
  localparam logic [7:0] SSEG_D7 = 8'hF8;
  localparam logic [7:0] SSEG_D8 = 8'h80;
  localparam logic [7:0] SSEG_D9 = 8'h90;

  // 9999 is the saturation value of the upstream Fibonacci datapath.
  function automatic logic is_saturated(input logic [3:0] d3, input logic [3:0] d2,
                                        input logic [3:0] d1, input logic [3:0] d0);
    return (d3 == 4'd9) && (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
  endfunction

endpackage

// File: rtl/bcd_sseg_display_mux_bcd_to_sseg.sv
// Combinational BCD to seven-segment decoder (active-low g..a); nibbles above 9
// decode to a dash.
module bcd_to_sseg
  import bcd_sseg_display_mux_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SSEG_DASH[6:0];
    case (i_bcd)
      4'd0:    o_seg = SSEG_D0[6:0];
      4'd1:    o_seg = SSEG_D1[6:0];
      4'd2:    o_seg = SSEG_D2[6:0];
      4'd3:    o_seg = SSEG_D3[6:0];
      4'd4:    o_seg = SSEG_D4[6:0];
      4'd5:    o_seg = SSEG_D5[6:0];
      4'd6:    o_seg = SSEG_D6[6:0];
      4'd7:    o_seg = SSEG_D7[6:0];
      4'd8:    o_seg = SSEG_D8[6:0];
      4'd9:    o_seg = SSEG_D9[6:0];
      default: o_seg = SSEG_DASH[6:0];
    endcase
  end

endmodule

// File: rtl/bcd_sseg_display_mux.sv
// Four-digit multiplexed common-anode display driver: latches BCD results,
// optional leading-zero blanking, flashes while showing the 9999 saturation value.
module bcd_sseg_display_mux
  import bcd_sseg_display_mux_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int FLASH_BITS   = 26
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic       i_blank_lz,
  input  logic [3:0] i_bcd3,
  input  logic [3:0] i_bcd2,
  input  logic [3:0] i_bcd1,
  input  logic [3:0] i_bcd0,
  output logic [3:0] o_an,
  output logic [7:0] o_sseg,
  output logic       o_showing
);

  logic [1:0]              r_state;
  logic [3:0][3:0]         r_dig;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [FLASH_BITS-1:0]   r_flash;
  logic [3:0]              r_an;
  logic [7:0]              r_sseg;

  logic [1:0] w_next_state;
  logic       w_load_sat;
  logic [1:0] w_idx;
  logic [3:0] w_nibble;
  logic [6:0] w_seg;
  logic [3:0] w_lz;
  logic       w_on_phase;
  logic       w_enable;

  assign w_load_sat = is_saturated(i_bcd3, i_bcd2, i_bcd1, i_bcd0);

  // Load beats clear when both strobes land in the same cycle.
  always_comb begin
    w_next_state = r_state;
    if (i_load) begin
      w_next_state = w_load_sat ? ST_SAT : ST_SHOW;
    end else if (i_clear) begin
      w_next_state = ST_BLANK;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_BLANK;
      r_dig   <= '0;
    end else begin
      r_state <= w_next_state;
      if (i_load) begin
        r_dig <= {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
      end
    end
  end

  // Flash phase restarts on every entry into SAT, including a repeated 9999 load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_refresh <= '0;
      r_flash   <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      if (i_load || (w_next_state != ST_SAT)) begin
        r_flash <= '0;
      end else begin
        r_flash <= r_flash + 1'b1;
      end
    end
  end

  assign w_idx    = r_refresh[REFRESH_BITS-1 -: 2];
  assign w_nibble = r_dig[w_idx];

  bcd_to_sseg u_dec (
    .i_bcd (w_nibble),
    .o_seg (w_seg)
  );

  // w_lz[k]: digit k and all higher digits are zero; digit 0 always lights.
  assign w_lz[3] = (r_dig[3] == 4'd0);
  assign w_lz[2] = w_lz[3] && (r_dig[2] == 4'd0);
  assign w_lz[1] = w_lz[2] && (r_dig[1] == 4'd0);
  assign w_lz[0] = 1'b0;

  assign w_on_phase = (r_state == ST_SHOW) ||
                      ((r_state == ST_SAT) && !r_flash[FLASH_BITS-1]);
  assign w_enable   = w_on_phase && !(i_blank_lz && w_lz[w_idx]);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_an   <= 4'hF;
      r_sseg <= SSEG_BLANK;
    end else if (w_enable) begin
      r_an   <= ~(4'b0001 << w_idx);
      r_sseg <= {1'b1, w_seg};
    end else begin
      r_an   <= 4'hF;
      r_sseg <= SSEG_BLANK;
    end
  end

  assign o_an      = r_an;
  assign o_sseg    = r_sseg;
  assign o_showing = (r_state == ST_SHOW) || (r_state == ST_SAT);

endmodule

// File: tb/tb_bcd_sseg_display_mux.sv
// Randomized bench for bcd_sseg_display_mux with a cycle-level behavioural model.
module tb_bcd_sseg_display_mux;

  localparam int RB = 4;
  localparam int FB = 6;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_load = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_blank_lz = 1'b0;
  logic [3:0] i_bcd3 = '0, i_bcd2 = '0, i_bcd1 = '0, i_bcd0 = '0;
  logic [3:0] o_an;
  logic [7:0] o_sseg;
  logic       o_showing;

  int total = 0;
  int bad   = 0;

  // Model: 0 = blank, 1 = show, 2 = saturated/flashing.
  int m_state;
  int m_cyc;
  int m_flash;
  int m_dig [4];
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bcd_sseg_display_mux #(.REFRESH_BITS(RB), .FLASH_BITS(FB)) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (i_load),
    .i_clear    (i_clear),
    .i_blank_lz (i_blank_lz),
    .i_bcd3     (i_bcd3),
    .i_bcd2     (i_bcd2),
    .i_bcd1     (i_bcd1),
    .i_bcd0     (i_bcd0),
    .o_an       (o_an),
    .o_sseg     (o_sseg),
    .o_showing  (o_showing)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cyc   = 0;
    m_flash = 0;
    for (int k = 0; k < 4; k++) m_dig[k] = 0;
  endtask

  // One clock: predict the registered outputs from the pre-edge model, advance
  // the model with the current inputs, then compare.
  task automatic step();
    logic [3:0] ea;
    logic [7:0] es;
    int idx, hi;
    bit lit;
    idx = (m_cyc / 4) % 4;
    hi  = 0;
    for (int k = 1; k < 4; k++) if (m_dig[k] != 0) hi = k;
    lit = (m_state == 1) || (m_state == 2 && ((m_flash / 32) % 2) == 0);
    if (i_blank_lz && idx > hi) lit = 0;
    ea = 4'hF;
    es = 8'hFF;
    if (lit) begin
      ea[idx] = 1'b0;
      es = (m_dig[idx] > 9) ? 8'hBF : seg_tab[m_dig[idx]];
    end
    @(posedge i_clk);
    #1;
    m_cyc++;
    if (i_load) begin
      m_dig[3] = i_bcd3; m_dig[2] = i_bcd2; m_dig[1] = i_bcd1; m_dig[0] = i_bcd0;
      if (m_dig[3] == 9 && m_dig[2] == 9 && m_dig[1] == 9 && m_dig[0] == 9) begin
        m_state = 2;
        m_flash = 0;
      end else begin
        m_state = 1;
      end
    end else if (i_clear) begin
      m_state = 0;
    end else if (m_state == 2) begin
      m_flash++;
    end
    check_val("an", 32'(o_an), 32'(ea));
    check_val("sseg", 32'(o_sseg), 32'(es));
    check_val("showing", 32'(o_showing), 32'(m_state != 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int d3, input int d2, input int d1, input int d0);
    i_bcd3 = 4'(d3); i_bcd2 = 4'(d2); i_bcd1 = 4'(d1); i_bcd0 = 4'(d0);
    i_load = 1'b1;
    step();
    i_load  = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_an"}, 32'(o_an), 32'hF);
    check_val({tag, "_sseg"}, 32'(o_sseg), 32'hFF);
    check_val({tag, "_showing"}, 32'(o_showing), 32'h0);
  endtask

  initial begin
    model_reset();
    #12;
    check_reset_outputs("rst");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    run(64);

    // Basic scan order, then leading-zero blanking.
    i_blank_lz = 1'b0;
    load(0, 1, 2, 3);
    run(16);
    i_blank_lz = 1'b1;
    load(0, 0, 5, 0);
    run(16);
    load(0, 0, 0, 0);
    run(16);

    // Saturation flash, re-load of 9999 inside SAT, then exit to SHOW.
    i_blank_lz = 1'b0;
    load(9, 9, 9, 9);
    run(100);
    load(9, 9, 9, 9);
    run(40);
    load(0, 0, 5, 5);
    run(70);

    // Invalid nibble, clear, and load-beats-clear.
    load(0, 10, 3, 4);
    run(16);
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    run(8);
    i_clear = 1'b1;
    load(1, 0, 15, 7);
    run(16);

    for (int i = 0; i < 2500; i++) begin
      int r;
      if ($urandom_range(0, 199) == 0) i_blank_lz = ~i_blank_lz;
      r = $urandom_range(0, 5);
      if (r == 0) begin
        i_bcd3 = 4'd9; i_bcd2 = 4'd9; i_bcd1 = 4'd9; i_bcd0 = 4'd9;
      end else if (r == 1) begin
        i_bcd3 = 4'($urandom_range(0, 15)); i_bcd2 = 4'($urandom_range(0, 15));
        i_bcd1 = 4'($urandom_range(0, 15)); i_bcd0 = 4'($urandom_range(0, 15));
      end else begin
        i_bcd3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        i_bcd2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        i_bcd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
        i_bcd0 = 4'($urandom_range(0, 9));
      end
      i_load  = ($urandom_range(0, 29) == 0);
      i_clear = ($urandom_range(0, 59) == 0);
      step();
    end
    i_load  = 1'b0;
    i_clear = 1'b0;
    i_blank_lz = 1'b0;

    // Asynchronous reset in the middle of a SAT scan.
    load(9, 9, 9, 9);
    run(7);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge i_clk);
    #1;
    check_reset_outputs("rst_held");
    #2;
    i_reset_n = 1'b1;
    run(40);
    load(1, 2, 3, 4);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_sseg_display_mux.md
# bcd_sseg_display_mux

Time-multiplexed driver for a four-digit common-anode seven-segment display. It sits directly downstream of the Fibonacci datapath and consumes that block's four BCD result digits and its done tick. It latches each new result, optionally blanks leading zeros, and flashes the display when the result is the saturation value 9999.

## Interface
- REFRESH_BITS, 18: width of the refresh counter. The top two bits select the active digit, so each digit is on for 2^(REFRESH_BITS-2) cycles.
- FLASH_BITS, 26: width of the flash counter. Its MSB is the flash phase, giving a half-period of 2^(FLASH_BITS-1) cycles.
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_load  in  1  single-cycle strobe; latch i_bcd3..i_bcd0 (driven from the Fibonacci done tick).
- i_clear  in  1  single-cycle strobe; return to the blank state.
- i_blank_lz  in  1  level; 1 enables leading-zero blanking.
- i_bcd3, i_bcd2, i_bcd1, i_bcd0  in  4 each  result digits, with bcd3 as the MSD.
- o_an  out  4  anode enables, active-low; bit n drives digit n.
- o_sseg  out  8  segments, active-low. Bit 7 = dp, bits 6..0 = g,f,e,d,c,b,a.
- o_showing  out  1  high while in SHOW or SAT.

## Operation
- **State machine** (states BLANK, SHOW, SAT):
  - BLANK is the reset state. All anodes are off.
  - i_load in any state latches the four digits. The next state is SAT if the latched value is 9,9,9,9, otherwise SHOW.
  - i_clear in any state sends the FSM to BLANK.
  - If i_load and i_clear are high in the same cycle, i_load wins.
- **Refresh counter:** free-running and wraps. The digit index is counter[REFRESH_BITS-1:REFRESH_BITS-2], scanning digit 0, 1, 2, 3, then back to 0.
- **Flash counter:**
  - Free-running in SAT. Cleared to 0 whenever the FSM enters SAT.
  - In SAT, anodes are forced off while the flash MSB is 1.
- **Segment decode:**
  - Digits 0 through 9 use standard patterns: 0→C0h, 1→F9h, 2→A4h, 3→B0h, 4→99h, 5→92h, 6→82h, 7→F8h, 8→80h, 9→90h.
  - A latched nibble above 9 displays a dash, BFh.
  - The decimal point is always off (bit 7 = 1).
- **Leading-zero blanking:**
  - Applies when i_blank_lz = 1.
  - Digit k (k = 3..1) is blanked (its anode held off) if digit k and every higher digit are 0.
  - Digit 0 is never blanked, so 0000 shows "0".
  - An invalid nibble (>9) counts as non-zero.
- **Blank anode value:** a blanked or disabled digit drives o_an bit = 1 and o_sseg = FFh.

## Timing
- **Registered outputs:** o_an and o_sseg are registered. They reflect the refresh index and latched data from the previous cycle, giving one cycle of latency.
- **Load latency:** with i_load high at edge N, the latch and state update at edge N. The outputs show the new data from edge N+1.
- **Anode pattern:** exactly one o_an bit is low in SHOW, or in SAT during the on-phase. No bits are low in BLANK.
- **Reset values (asynchronous):**
  - State = BLANK, all counters = 0, latched digits = 0.
  - o_an = 1111b, o_sseg = FFh, o_showing = 0.
- **Reset mid-scan:** the block returns to the reset values immediately. Scanning restarts at digit 0 after deassertion.
- **i_load during SAT:** a load with a non-9999 value exits to SHOW at the same edge. A load with 9999 again restarts the flash counter.
- **Mid-scan load:** i_load coinciding with a digit boundary does not disturb the refresh counter.

## Structure
- **Shared package** (e.g. sseg_pkg), holding:
  - the state encoding (2 bits: BLANK=00, SHOW=01, SAT=10);
  - the segment constants SSEG_BLANK=FFh and SSEG_DASH=BFh;
  - the ten digit patterns.
- **Sub-module bcd_to_sseg:** combinational 4-bit to 7-bit decoder, including the dash for invalid nibbles. It is instantiated once, after the digit mux.
- **Top level:** the FSM, the latch, both counters, the blanking logic and the output registers stay in the top module.

## Test plan
Benches use REFRESH_BITS=4 (4 cycles per digit) and FLASH_BITS=6.
1. **Reset:** hold i_reset_n=0 → o_an=1111b, o_sseg=FFh, o_showing=0. After release with no load → outputs unchanged for 64 cycles.
2. **Basic load:** load 0,1,2,3 (i_blank_lz=0) → over one 16-cycle scan, the bench sees o_an 1110b/C0h... wait, digit 0 holds 3, so the expected sequence is o_an 1110b/B0h, 1101b/A4h, 1011b/F9h, 0111b/C0h, each for 4 cycles. o_showing=1.
3. **Leading-zero blanking:** load 0,0,5,0 with i_blank_lz=1 → digits 3 and 2 are never enabled. Digit 1 shows 92h and digit 0 shows C0h. Load 0,0,0,0 → only digit 0 is enabled, showing C0h.
4. **Saturation flash:** load 9,9,9,9 → all digits show 90h for 32 cycles, then o_an=1111b for 32 cycles, repeating. A later load of 0,0,5,5 → SHOW with no flashing.
5. **Invalid nibble and clear:** load nibble Ah in digit 2 → that digit shows BFh. Pulse i_clear → o_an=1111b from the next cycle. i_load and i_clear in the same cycle → SHOW.
6. **Mid-scan reset:** assert i_reset_n=0 mid-scan during SAT → outputs go to reset values without waiting for a clock edge. After release, state is BLANK and the latched data is 0.
